tx_arbiter: RTL and testbench

Arbitrates the single PD PHY transmitter among three requesters: Hard/Cable Reset signalling, automatic GoodCRC responses from the receive path, and ordinary messages from the protocol transmit state machine. It sits between those requesters and the PHY. It enforces priority, the bus-idle check, Hard Reset preemption and the inter-frame gap. It also generates the transmit-type code for the PHY and the success and discard pulses that the protocol layer consumes.

---
 rtl/tx_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_tx_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// tx_arbiter: shares the PD PHY transmitter among Hard/Cable Reset, GoodCRC and message requesters.
// Optional define TX_ARB_IDLE_TIMEOUT_EN bounds the wait for bus idle to IDLE_TIMEOUT cycles.
module tx_arbiter #(
  parameter int IFG_CYCLES   = 8,
  parameter int IDLE_TIMEOUT = 64,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       msg_req,
  input  logic [2:0] msg_sop,
  input  logic       gcrc_req,
  input  logic [2:0] gcrc_sop,
  input  logic       hrst_req,
  input  logic       hrst_type,
  input  logic       bus_idle,
  input  logic       rx_busy,
  input  logic       phy_done,
  output logic       phy_start,
  output logic       phy_abort,
  output logic [2:0] phy_type,
  output logic       msg_grant,
  output logic       gcrc_grant,
  output logic       hrst_grant,
  output logic       msg_done,
  output logic       gcrc_done,
  output logic       hrst_done,
  output logic       msg_discarded
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_IDLE, S_START, S_ACTIVE, S_GAP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_MSG, OWN_GCRC, OWN_HRST} owner_t;

  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(IFG_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(IDLE_TIMEOUT - 1);

  state_t           state_reg, state_next;
  owner_t           owner_reg, owner_next;
  logic [2:0]       type_reg, type_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic phy_start_reg, phy_abort_reg;
  logic msg_grant_reg, gcrc_grant_reg, hrst_grant_reg;
  logic msg_done_reg, gcrc_done_reg, hrst_done_reg, discard_reg;
  logic abort_next, msg_done_next, gcrc_done_next, hrst_done_next, discard_next;
  logic grant_phase;

  logic [2:0] hrst_code;
  assign hrst_code = hrst_type ? 3'd6 : 3'd5;

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    type_next      = type_reg;
    cnt_next       = cnt_reg;
    abort_next     = 1'b0;
    msg_done_next  = 1'b0;
    gcrc_done_next = 1'b0;
    hrst_done_next = 1'b0;
    discard_next   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // Reset signalling goes straight out without checking for bus idle.
        if (hrst_req) begin
          owner_next = OWN_HRST;
          type_next  = hrst_code;
          state_next = S_START;
        end else if (gcrc_req) begin
          owner_next = OWN_GCRC;
          type_next  = gcrc_sop;
          cnt_next   = WAIT_LOAD;
          state_next = S_WAIT_IDLE;
        end else if (msg_req) begin
          owner_next = OWN_MSG;
          type_next  = msg_sop;
          cnt_next   = WAIT_LOAD;
          state_next = S_WAIT_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        if (hrst_req) begin
          discard_next = (owner_reg == OWN_MSG);
          owner_next   = OWN_HRST;
          type_next    = hrst_code;
          state_next   = S_START;
        end else if (rx_busy && (owner_reg == OWN_MSG)) begin
          discard_next = 1'b1;
          owner_next   = OWN_NONE;
          cnt_next     = GAP_LOAD;
          state_next   = S_GAP;
        end else if (bus_idle) begin
          state_next = S_START;
        end
`ifdef TX_ARB_IDLE_TIMEOUT_EN
        else if (cnt_reg == '0) begin
          // A timed-out GoodCRC is dropped without any indication.
          discard_next = (owner_reg == OWN_MSG);
          owner_next   = OWN_NONE;
          cnt_next     = GAP_LOAD;
          state_next   = S_GAP;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
`endif
      end

      S_START: state_next = S_ACTIVE;

      S_ACTIVE: begin
        if (phy_done) begin
          msg_done_next  = (owner_reg == OWN_MSG);
          gcrc_done_next = (owner_reg == OWN_GCRC);
          hrst_done_next = (owner_reg == OWN_HRST);
          owner_next     = OWN_NONE;
          cnt_next       = GAP_LOAD;
          state_next     = S_GAP;
        end else if (hrst_req && (owner_reg != OWN_HRST)) begin
          // Preemption: keep HRST as owner so the gap returns to START.
          abort_next   = 1'b1;
          discard_next = (owner_reg == OWN_MSG);
          owner_next   = OWN_HRST;
          type_next    = hrst_code;
          cnt_next     = GAP_LOAD;
          state_next   = S_GAP;
        end
      end

      S_GAP: begin
        if (cnt_reg == '0) begin
          state_next = (owner_reg == OWN_HRST) ? S_START : S_IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      default: begin
        owner_next = OWN_NONE;
        state_next = S_IDLE;
      end
    endcase
  end

  assign grant_phase = (state_next == S_START) || (state_next == S_ACTIVE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      owner_reg      <= OWN_NONE;
      type_reg       <= 3'd0;
      cnt_reg        <= '0;
      phy_start_reg  <= 1'b0;
      phy_abort_reg  <= 1'b0;
      msg_grant_reg  <= 1'b0;
      gcrc_grant_reg <= 1'b0;
      hrst_grant_reg <= 1'b0;
      msg_done_reg   <= 1'b0;
      gcrc_done_reg  <= 1'b0;
      hrst_done_reg  <= 1'b0;
      discard_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      type_reg       <= type_next;
      cnt_reg        <= cnt_next;
      phy_start_reg  <= (state_next == S_START);
      phy_abort_reg  <= abort_next;
      msg_grant_reg  <= grant_phase && (owner_next == OWN_MSG);
      gcrc_grant_reg <= grant_phase && (owner_next == OWN_GCRC);
      hrst_grant_reg <= grant_phase && (owner_next == OWN_HRST);
      msg_done_reg   <= msg_done_next;
      gcrc_done_reg  <= gcrc_done_next;
      hrst_done_reg  <= hrst_done_next;
      discard_reg    <= discard_next;
    end
  end

  assign phy_start     = phy_start_reg;
  assign phy_abort     = phy_abort_reg;
  assign phy_type      = type_reg;
  assign msg_grant     = msg_grant_reg;
  assign gcrc_grant    = gcrc_grant_reg;
  assign hrst_grant    = hrst_grant_reg;
  assign msg_done      = msg_done_reg;
  assign gcrc_done     = gcrc_done_reg;
  assign hrst_done     = hrst_done_reg;
  assign msg_discarded = discard_reg;

endmodule

// File: tb/tb_tx_arbiter.sv
// Scoreboard bench for tx_arbiter: scripted stimulus queues expected output events, a monitor checks them.
module tb_tx_arbiter;

  localparam logic [5:0] P_START = 6'b100000;
  localparam logic [5:0] P_ABORT = 6'b010000;
  localparam logic [5:0] P_MDONE = 6'b001000;
  localparam logic [5:0] P_GDONE = 6'b000100;
  localparam logic [5:0] P_HDONE = 6'b000010;
  localparam logic [5:0] P_MDISC = 6'b000001;
  localparam logic [2:0] G_NONE  = 3'b000;
  localparam logic [2:0] G_MSG   = 3'b100;
  localparam logic [2:0] G_GCRC  = 3'b010;
  localparam logic [2:0] G_HRST  = 3'b001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       msg_req, gcrc_req, hrst_req, hrst_type, bus_idle, rx_busy, phy_done;
  logic [2:0] msg_sop, gcrc_sop;
  logic       phy_start, phy_abort, msg_grant, gcrc_grant, hrst_grant;
  logic       msg_done, gcrc_done, hrst_done, msg_discarded;
  logic [2:0] phy_type;

  tx_arbiter #(.IFG_CYCLES(8), .IDLE_TIMEOUT(64), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .msg_req(msg_req), .msg_sop(msg_sop),
    .gcrc_req(gcrc_req), .gcrc_sop(gcrc_sop),
    .hrst_req(hrst_req), .hrst_type(hrst_type),
    .bus_idle(bus_idle), .rx_busy(rx_busy), .phy_done(phy_done),
    .phy_start(phy_start), .phy_abort(phy_abort), .phy_type(phy_type),
    .msg_grant(msg_grant), .gcrc_grant(gcrc_grant), .hrst_grant(hrst_grant),
    .msg_done(msg_done), .gcrc_done(gcrc_done), .hrst_done(hrst_done),
    .msg_discarded(msg_discarded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [5:0] pulses;
    logic [2:0] ptype;
    logic [2:0] grants;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  t0, t1;
  logic [2:0] s6_type;

  task automatic push(input int c, input logic [5:0] p, input logic [2:0] t, input logic [2:0] g);
    ev_t e;
    e.cyc = c; e.pulses = p; e.ptype = t; e.grants = g;
    exp_q.push_back(e);
  endtask

  task automatic to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (cyc %0d)", name, got, want, cyc);
    end else begin
      $display("chk %s = %h ok (cyc %0d)", name, got, cyc);
    end
  endtask

  task automatic drain(input string name);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d expected events still pending, required 0 (next due cyc %0d)",
               name, exp_q.size(), exp_q[0].cyc);
      exp_q.delete();
    end else begin
      $display("chk %s drained ok (cyc %0d)", name, cyc);
    end
  endtask

  function automatic logic [15:0] all_outs();
    return {4'd0, phy_start, phy_abort, phy_type, msg_grant, gcrc_grant, hrst_grant,
            msg_done, gcrc_done, hrst_done, msg_discarded};
  endfunction

  // Monitor: every cycle with any pulse output high is one transaction.
  always @(negedge clk) begin : mon
    logic [5:0] p;
    logic [2:0] g;
    ev_t        e;
    p = {phy_start, phy_abort, msg_done, gcrc_done, hrst_done, msg_discarded};
    g = {msg_grant, gcrc_grant, hrst_grant};
    if (p != 6'd0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got cyc=%0d pulses=%b type=%0d grants=%b, required no event",
                 cyc, p, phy_type, g);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.pulses != p || e.ptype != phy_type || e.grants != g) begin
          n_bad++;
          $display("FAIL event: got cyc=%0d pulses=%b type=%0d grants=%b, required cyc=%0d pulses=%b type=%0d grants=%b",
                   cyc, p, phy_type, g, e.cyc, e.pulses, e.ptype, e.grants);
        end else begin
          $display("ev cyc=%0d pulses=%b type=%0d grants=%b ok", cyc, p, phy_type, g);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    msg_req = 0; gcrc_req = 0; hrst_req = 0; hrst_type = 0;
    bus_idle = 0; rx_busy = 0; phy_done = 0; msg_sop = 0; gcrc_sop = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 16'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", all_outs(), 16'd0);

    // S1: message with bus idle, then a second message exposing the gap length.
    t0 = cyc;
    push(t0 + 2,  P_START, 3'd1, G_MSG);
    push(t0 + 23, P_MDONE, 3'd1, G_NONE);
    push(t0 + 33, P_START, 3'd2, G_MSG);
    push(t0 + 41, P_MDONE, 3'd2, G_NONE);
    bus_idle = 1; msg_sop = 3'd1; msg_req = 1;
    to(t0 + 10); check("s1_grant_active", {13'd0, msg_grant, gcrc_grant, hrst_grant}, {13'd0, G_MSG});
    to(t0 + 22); phy_done = 1;
    to(t0 + 23); phy_done = 0; msg_req = 0;
    to(t0 + 24); msg_sop = 3'd2; msg_req = 1;
    to(t0 + 40); phy_done = 1;
    to(t0 + 41); phy_done = 0; msg_req = 0;
    to(t0 + 50); drain("s1_msg");

    // S2: GoodCRC and message together; GoodCRC first.
    t0 = cyc;
    push(t0 + 2,  P_START, 3'd0, G_GCRC);
    push(t0 + 11, P_GDONE, 3'd0, G_NONE);
    push(t0 + 21, P_START, 3'd3, G_MSG);
    push(t0 + 26, P_MDONE, 3'd3, G_NONE);
    gcrc_sop = 3'd0; gcrc_req = 1; msg_sop = 3'd3; msg_req = 1;
    to(t0 + 10); phy_done = 1;
    to(t0 + 11); phy_done = 0; gcrc_req = 0;
    to(t0 + 25); phy_done = 1;
    to(t0 + 26); phy_done = 0; msg_req = 0;
    to(t0 + 35); drain("s2_gcrc_msg");

    // S3: Cable Reset preempts an active message.
    t0 = cyc;
    push(t0 + 2,  P_START, 3'd0, G_MSG);
    push(t0 + 6,  P_ABORT | P_MDISC, 3'd6, G_NONE);
    push(t0 + 14, P_START, 3'd6, G_HRST);
    push(t0 + 21, P_HDONE, 3'd6, G_NONE);
    msg_sop = 3'd0; msg_req = 1;
    to(t0 + 5);  hrst_type = 1; hrst_req = 1;
    to(t0 + 6);  msg_req = 0;
    to(t0 + 20); phy_done = 1;
    to(t0 + 21); phy_done = 0; hrst_req = 0;
    to(t0 + 30); drain("s3_preempt");

    // S4: bus busy, then receive activity discards the message.
    t0 = cyc;
    push(t0 + 6, P_MDISC, 3'd2, G_NONE);
    bus_idle = 0; msg_sop = 3'd2; msg_req = 1;
    to(t0 + 3); check("s4_no_grant_wait", {13'd0, msg_grant, gcrc_grant, hrst_grant}, {13'd0, G_NONE});
    to(t0 + 5); rx_busy = 1;
    to(t0 + 6); rx_busy = 0; msg_req = 0;
    to(t0 + 15); drain("s4_rx_busy");

    // S5: bus never idles.
    t0 = cyc;
    msg_sop = 3'd4; msg_req = 1;
`ifdef TX_ARB_IDLE_TIMEOUT_EN
    push(t0 + 65, P_MDISC, 3'd4, G_NONE);
    to(t0 + 65); msg_req = 0;
    to(t0 + 74); drain("s5_timeout");
`else
    to(t0 + 1001); drain("s5_no_timeout");
    check("s5_still_waiting", {13'd0, msg_grant, gcrc_grant, hrst_grant}, {13'd0, G_NONE});
`endif

    // S6: asynchronous reset while a message is active.
    t0 = cyc;
    bus_idle = 1;
`ifdef TX_ARB_IDLE_TIMEOUT_EN
    s6_type = 3'd1;
    push(t0 + 2, P_START, 3'd1, G_MSG);
    msg_sop = 3'd1; msg_req = 1;
`else
    s6_type = 3'd4;
    push(t0 + 1, P_START, 3'd4, G_MSG);
`endif
    to(t0 + 6);
    check("s6_active_grant", {13'd0, msg_grant, gcrc_grant, hrst_grant}, {13'd0, G_MSG});
    check("s6_active_type", {13'd0, phy_type}, {13'd0, s6_type});
    #2 reset = 1'b0;
    #1 check("s6_async_reset", all_outs(), 16'd0);
    msg_req = 0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("s6_after_release", all_outs(), 16'd0);
    drain("s6_reset");
    t1 = cyc;
    push(t1 + 1, P_START, 3'd5, G_HRST);
    push(t1 + 5, P_HDONE, 3'd5, G_NONE);
    hrst_type = 0; hrst_req = 1;
    to(t1 + 4); phy_done = 1;
    to(t1 + 5); phy_done = 0; hrst_req = 0;
    to(t1 + 14); drain("s6_hrst_from_idle");

    // S7: bus_idle and hrst_req rise together in WAIT_IDLE; hrst wins.
    t0 = cyc;
    push(t0 + 4, P_START | P_MDISC, 3'd5, G_HRST);
    push(t0 + 9, P_HDONE, 3'd5, G_NONE);
    bus_idle = 0; msg_sop = 3'd0; msg_req = 1;
    to(t0 + 3); bus_idle = 1; hrst_type = 0; hrst_req = 1;
    to(t0 + 4); msg_req = 0;
    to(t0 + 8); phy_done = 1;
    to(t0 + 9); phy_done = 0; hrst_req = 0;
    to(t0 + 18); drain("s7_hrst_vs_idle");

    // S8: phy_done and hrst_req together in ACTIVE; done wins, hrst after the gap.
    t0 = cyc;
    push(t0 + 2,  P_START, 3'd0, G_MSG);
    push(t0 + 7,  P_MDONE, 3'd0, G_NONE);
    push(t0 + 16, P_START, 3'd6, G_HRST);
    push(t0 + 21, P_HDONE, 3'd6, G_NONE);
    msg_sop = 3'd0; msg_req = 1;
    to(t0 + 6);  phy_done = 1; hrst_type = 1; hrst_req = 1;
    to(t0 + 7);  phy_done = 0; msg_req = 0;
    to(t0 + 20); phy_done = 1;
    to(t0 + 21); phy_done = 0; hrst_req = 0;
    to(t0 + 30); drain("s8_done_vs_hrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
